move_link_tx: RTL and testbench

//  Transmit side of the board-to-board move link. Takes local one-hot move

---
 rtl/move_link_tx.sv | 181 ++++++++++++++++++
 tb/tb_move_link_tx.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/move_link_tx.sv
// -----------------------------------------------------------------------------
// move_link_tx
//
// Transmit side of the board-to-board move link. Local one-hot move pulses
// (left/right/put) are queued in a small FIFO. Each queued move is then sent
// on the peer wires as a stretched high pulse followed by a guaranteed low gap.
// The peer's synchroniser and edge detector can only see a pulse that is held
// long enough and separated from the next one, which is why pulses are shaped
// this way.
//
// Ports:
//   clk       system clock
//   rst       synchronous, active-high reset
//   enable    1 = accept new moves; a send already in progress is not stopped
//   lrp_in    one-cycle move pulse, [2]=left [1]=right [0]=put
//   tx_left   registered wire to the peer "left" input
//   tx_right  registered wire to the peer "right" input
//   tx_put    registered wire to the peer "receive/put" input
//   busy      a move is being sent or is waiting in the queue
//   full      the queue holds FIFO_DEPTH moves
//   drop      one-cycle pulse: a move arrived while full and was discarded
//   sent      one-cycle pulse during the last gap cycle of each move
// -----------------------------------------------------------------------------
module move_link_tx #(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 4,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [2:0] lrp_in,
    output logic       tx_left,
    output logic       tx_right,
    output logic       tx_put,
    output logic       busy,
    output logic       full,
    output logic       drop,
    output logic       sent
);

    localparam int ADDR_W  = $clog2(FIFO_DEPTH);
    localparam int PTR_W   = ADDR_W + 1;
    localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    localparam logic [1:0] STATE_IDLE = 2'd0;
    localparam logic [1:0] STATE_HOLD = 2'd1;
    localparam logic [1:0] STATE_GAP  = 2'd2;

    localparam logic [1:0] CODE_LEFT  = 2'b10;
    localparam logic [1:0] CODE_RIGHT = 2'b01;
    localparam logic [1:0] CODE_PUT   = 2'b11;

    logic [1:0]       fifoMem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       tx_q, tx_d;
    logic             drop_q, drop_d;

    logic             fifoEmpty;
    logic             fifoFull;
    logic             moveValid;
    logic [1:0]       moveCode;
    logic [1:0]       headCode;
    logic             pop;
    logic             push;

    // Pointers carry one extra wrap bit so that equal addresses can be told
    // apart as either empty (same lap) or full (one lap apart).
    assign fifoEmpty = (wrPtr_q == rdPtr_q);
    assign fifoFull  = (wrPtr_q[PTR_W-1] != rdPtr_q[PTR_W-1]) &&
                       (wrPtr_q[ADDR_W-1:0] == rdPtr_q[ADDR_W-1:0]);

    // Multi-hot input is resolved with left taking priority over right over put.
    always_comb begin
        moveValid = enable && (lrp_in != 3'b000);
        if (lrp_in[2]) begin
            moveCode = CODE_LEFT;
        end else if (lrp_in[1]) begin
            moveCode = CODE_RIGHT;
        end else begin
            moveCode = CODE_PUT;
        end
    end

    assign headCode = fifoMem_q[rdPtr_q[ADDR_W-1:0]];

    // A pop in the same cycle frees the head slot, so a full queue can still
    // take a new move when the FSM is about to pull one out.
    assign pop  = (state_q == STATE_IDLE) && !fifoEmpty;
    assign push = moveValid && (!fifoFull || pop);

    // Next-state logic for the queue pointers, the send FSM and the wire register.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tx_d    = tx_q;
        rdPtr_d = rdPtr_q;
        wrPtr_d = push ? (wrPtr_q + PTR_W'(1)) : wrPtr_q;
        drop_d  = moveValid && !push;

        case (state_q)
            STATE_IDLE: begin
                if (pop) begin
                    rdPtr_d = rdPtr_q + PTR_W'(1);
                    cnt_d   = '0;
                    state_d = STATE_HOLD;
                    case (headCode)
                        CODE_LEFT:  tx_d = 3'b100;
                        CODE_RIGHT: tx_d = 3'b010;
                        CODE_PUT:   tx_d = 3'b001;
                        default:    tx_d = 3'b000;
                    endcase
                end
            end
            STATE_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    tx_d    = 3'b000;
                    cnt_d   = '0;
                    state_d = STATE_GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STATE_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = STATE_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                tx_d    = 3'b000;
                cnt_d   = '0;
                state_d = STATE_IDLE;
            end
        endcase
    end

    // Control registers; reset empties the queue and aborts any pulse at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            state_q <= STATE_IDLE;
            cnt_q   <= '0;
            tx_q    <= 3'b000;
            drop_q  <= 1'b0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tx_q    <= tx_d;
            drop_q  <= drop_d;
        end
    end

    // Queue storage needs no reset: the pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fifoMem_q[wrPtr_q[ADDR_W-1:0]] <= moveCode;
        end
    end

    assign tx_left  = tx_q[2];
    assign tx_right = tx_q[1];
    assign tx_put   = tx_q[0];
    assign busy     = (state_q != STATE_IDLE) || !fifoEmpty;
    assign full     = fifoFull;
    assign drop     = drop_q;
    assign sent     = (state_q == STATE_GAP) && (cnt_q == GAP_LAST);

endmodule

// File: tb/tb_move_link_tx.sv
// -----------------------------------------------------------------------------
// tb_move_link_tx
//
// Self-checking bench for move_link_tx. A queue-based reference model predicts
// every output on every cycle. Directed table vectors, scenario sequences and
// random traffic all run through the same per-cycle stimulus task.
// -----------------------------------------------------------------------------
module tb_move_link_tx;

    localparam int HOLD  = 4;
    localparam int GAP   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [2:0] lrp_in;
    logic       tx_left, tx_right, tx_put;
    logic       busy, full, drop, sent;
    logic [2:0] txBus;

    int checkCount = 0;
    int errorCount = 0;

    // Reference model state: pending moves (0=L, 1=R, 2=P), the move on the
    // wires (-1 = none) and how many cycles into its hold+gap period we are.
    int modelQueue[$];
    int curMove     = -1;
    int phase       = 0;
    bit dropPending = 1'b0;

    // Values seen at the most recent sample point, plus scenario bookkeeping.
    logic [2:0] obsTx;
    logic       obsBusy, obsFull, obsDrop, obsSent;
    logic [2:0] prevTx = 3'b000;
    logic [2:0] pulseLog[$];
    int         sentCount = 0;
    bit         sawFull   = 1'b0;
    bit         sawDrop   = 1'b0;
    bit         sawBusy   = 1'b0;

    typedef struct {
        logic       r;
        logic       e;
        logic [2:0] l;
        logic [2:0] tx;
        logic       busy;
        logic       full;
        logic       drop;
        logic       sent;
    } vec_t;

    vec_t vecs[$];

    move_link_tx #(
        .HOLD_CYCLES(HOLD),
        .GAP_CYCLES (GAP),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .lrp_in  (lrp_in),
        .tx_left (tx_left),
        .tx_right(tx_right),
        .tx_put  (tx_put),
        .busy    (busy),
        .full    (full),
        .drop    (drop),
        .sent    (sent)
    );

    assign txBus = {tx_left, tx_right, tx_put};

    // 50 MHz clock.
    always #10 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic e, input logic [2:0] l,
                                input logic [2:0] tx, input logic b, input logic f,
                                input logic d, input logic s);
        vec_t v;
        v.r = r; v.e = e; v.l = l; v.tx = tx;
        v.busy = b; v.full = f; v.drop = d; v.sent = s;
        return v;
    endfunction

    function automatic logic [2:0] modelTx();
        if (curMove >= 0 && phase < HOLD) begin
            return 3'b100 >> curMove;
        end
        return 3'b000;
    endfunction

    function automatic int decodeMove(input logic [2:0] l);
        if (l[2]) return 0;
        if (l[1]) return 1;
        return 2;
    endfunction

    task automatic checkSignal(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Advance the reference model by one clock edge with the given inputs.
    task automatic modelEdge(input logic r, input logic e, input logic [2:0] l);
        bit popNow;
        if (r) begin
            modelQueue.delete();
            curMove     = -1;
            phase       = 0;
            dropPending = 1'b0;
        end else begin
            popNow = (curMove < 0) && (modelQueue.size() > 0);
            if (curMove >= 0) begin
                if (phase == HOLD + GAP - 1) curMove = -1;
                else phase++;
            end
            if (popNow) begin
                curMove = modelQueue.pop_front();
                phase   = 0;
            end
            if (e && l != 3'b000) begin
                if (modelQueue.size() < DEPTH) begin
                    modelQueue.push_back(decodeMove(l));
                    dropPending = 1'b0;
                end else begin
                    dropPending = 1'b1;
                end
            end else begin
                dropPending = 1'b0;
            end
        end
    endtask

    task automatic checkOutput();
        checkSignal("tx",     32'(txBus), 32'(modelTx()));
        checkSignal("busy",   32'(busy),  32'((curMove >= 0) || (modelQueue.size() > 0)));
        checkSignal("full",   32'(full),  32'(modelQueue.size() == DEPTH));
        checkSignal("drop",   32'(drop),  32'(dropPending));
        checkSignal("sent",   32'(sent),  32'((curMove >= 0) && (phase == HOLD + GAP - 1)));
        checkSignal("onehot", 32'($countones(txBus) <= 1), 32'(1));
    endtask

    // One full clock cycle: drive inputs, sample outputs on the falling edge,
    // then let the DUT and the model both take the rising edge.
    task automatic applyStimulus(input logic r, input logic e, input logic [2:0] l,
                                 input bit doCheck);
        rst    = r;
        enable = e;
        lrp_in = l;
        @(negedge clk);
        obsTx   = txBus;
        obsBusy = busy;
        obsFull = full;
        obsDrop = drop;
        obsSent = sent;
        if (doCheck) begin
            checkOutput();
            if (obsTx != 3'b000 && prevTx == 3'b000) pulseLog.push_back(obsTx);
            if (obsSent) sentCount++;
            if (obsFull) sawFull = 1'b1;
            if (obsDrop) sawDrop = 1'b1;
            if (obsBusy) sawBusy = 1'b1;
        end
        prevTx = obsTx;
        @(posedge clk);
        modelEdge(r, e, l);
        #1;
    endtask

    task automatic clearLog();
        pulseLog.delete();
        sentCount = 0;
        sawFull   = 1'b0;
        sawDrop   = 1'b0;
        sawBusy   = 1'b0;
    endtask

    // Idle the inputs until busy is seen low, within a fixed cycle budget.
    task automatic runUntilIdle(input int bound, output int cycles);
        cycles = 0;
        for (int k = 0; k < bound; k++) begin
            applyStimulus(1'b0, 1'b1, 3'b000, 1'b1);
            cycles++;
            if (!obsBusy) break;
        end
        checkSignal("drainDone", 32'(obsBusy), 32'(0));
    endtask

    initial begin
        int cycles;
        logic [2:0] expLog[$];

        rst    = 1'b1;
        enable = 1'b0;
        lrp_in = 3'b000;

        // Reset, then a single left move issued in cycle N.
        vecs.push_back(mk(1, 1, 3'b100, 3'b000, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 3'b100, 3'b000, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 3'b100, 3'b000, 0, 0, 0, 0));  // N
        vecs.push_back(mk(0, 1, 3'b000, 3'b000, 1, 0, 0, 0));  // N+1
        for (int i = 0; i < HOLD; i++)
            vecs.push_back(mk(0, 1, 3'b000, 3'b100, 1, 0, 0, 0)); // N+2..N+5
        for (int i = 0; i < GAP - 1; i++)
            vecs.push_back(mk(0, 1, 3'b000, 3'b000, 1, 0, 0, 0)); // N+6..N+8
        vecs.push_back(mk(0, 1, 3'b000, 3'b000, 1, 0, 0, 1));  // N+9
        vecs.push_back(mk(0, 1, 3'b000, 3'b000, 0, 0, 0, 0));  // N+10

        applyStimulus(1'b1, 1'b0, 3'b000, 1'b0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].r, vecs[i].e, vecs[i].l, 1'b1);
            checkSignal($sformatf("vec%0d.tx", i),   32'(obsTx),   32'(vecs[i].tx));
            checkSignal($sformatf("vec%0d.busy", i), 32'(obsBusy), 32'(vecs[i].busy));
            checkSignal($sformatf("vec%0d.full", i), 32'(obsFull), 32'(vecs[i].full));
            checkSignal($sformatf("vec%0d.drop", i), 32'(obsDrop), 32'(vecs[i].drop));
            checkSignal($sformatf("vec%0d.sent", i), 32'(obsSent), 32'(vecs[i].sent));
        end

        // Burst L,R,P,P: four pulses in order, busy low 34 cycles after the burst.
        clearLog();
        applyStimulus(1'b0, 1'b1, 3'b100, 1'b1);
        applyStimulus(1'b0, 1'b1, 3'b010, 1'b1);
        applyStimulus(1'b0, 1'b1, 3'b001, 1'b1);
        applyStimulus(1'b0, 1'b1, 3'b001, 1'b1);
        runUntilIdle(100, cycles);
        checkSignal("burstDrainCycles", 32'(cycles), 32'(34));
        checkSignal("burstSent", 32'(sentCount), 32'(4));
        expLog = '{3'b100, 3'b010, 3'b001, 3'b001};
        checkSignal("burstPulses", 32'(pulseLog.size()), 32'(4));
        if (pulseLog.size() == 4)
            foreach (expLog[i]) checkSignal($sformatf("burstOrder%0d", i), 32'(pulseLog[i]), 32'(expLog[i]));

        // Overflow: six moves back to back, the sixth is dropped.
        clearLog();
        applyStimulus(1'b0, 1'b1, 3'b100, 1'b1);
        applyStimulus(1'b0, 1'b1, 3'b010, 1'b1);
        applyStimulus(1'b0, 1'b1, 3'b001, 1'b1);
        applyStimulus(1'b0, 1'b1, 3'b100, 1'b1);
        applyStimulus(1'b0, 1'b1, 3'b010, 1'b1);
        applyStimulus(1'b0, 1'b1, 3'b001, 1'b1);
        runUntilIdle(100, cycles);
        checkSignal("ovfSawFull", 32'(sawFull), 32'(1));
        checkSignal("ovfSawDrop", 32'(sawDrop), 32'(1));
        expLog = '{3'b100, 3'b010, 3'b001, 3'b100, 3'b010};
        checkSignal("ovfPulses", 32'(pulseLog.size()), 32'(5));
        if (pulseLog.size() == 5)
            foreach (expLog[i]) checkSignal($sformatf("ovfOrder%0d", i), 32'(pulseLog[i]), 32'(expLog[i]));

        // Priority and enable.
        clearLog();
        applyStimulus(1'b0, 1'b1, 3'b111, 1'b1);
        runUntilIdle(40, cycles);
        applyStimulus(1'b0, 1'b1, 3'b011, 1'b1);
        runUntilIdle(40, cycles);
        checkSignal("prioPulses", 32'(pulseLog.size()), 32'(2));
        if (pulseLog.size() == 2) begin
            checkSignal("prio111", 32'(pulseLog[0]), 32'(3'b100));
            checkSignal("prio011", 32'(pulseLog[1]), 32'(3'b010));
        end
        clearLog();
        for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b0, 3'b001, 1'b1);
        checkSignal("disabledBusy", 32'(sawBusy), 32'(0));
        checkSignal("disabledDrop", 32'(sawDrop), 32'(0));
        checkSignal("disabledPulses", 32'(pulseLog.size()), 32'(0));

        // Reset during the second high cycle of a right pulse.
        applyStimulus(1'b0, 1'b1, 3'b010, 1'b1);
        applyStimulus(1'b0, 1'b1, 3'b100, 1'b1);
        applyStimulus(1'b0, 1'b1, 3'b001, 1'b1);
        checkSignal("midHoldFirst", 32'(obsTx), 32'(3'b010));
        applyStimulus(1'b1, 1'b1, 3'b000, 1'b1);
        checkSignal("midHoldSecond", 32'(obsTx), 32'(3'b010));
        applyStimulus(1'b0, 1'b1, 3'b000, 1'b1);
        checkSignal("afterRstTx", 32'(obsTx), 32'(0));
        checkSignal("afterRstBusy", 32'(obsBusy), 32'(0));
        clearLog();
        applyStimulus(1'b0, 1'b1, 3'b001, 1'b1);
        runUntilIdle(40, cycles);
        checkSignal("freshPulses", 32'(pulseLog.size()), 32'(1));
        if (pulseLog.size() == 1) checkSignal("freshPut", 32'(pulseLog[0]), 32'(3'b001));
        checkSignal("freshSent", 32'(sentCount), 32'(1));

        // Random traffic against the model, with occasional resets.
        for (int i = 0; i < 500; i++) begin
            logic       r;
            logic       e;
            logic [2:0] l;
            r = ($urandom_range(0, 199) == 0);
            e = ($urandom_range(0, 9) != 0);
            l = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            applyStimulus(r, e, l, 1'b1);
        end
        runUntilIdle(100, cycles);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
